// File: rtl/crc_5bit_gen.sv
// rtl/crc_5bit_gen.sv - USB token CRC5 serializer
//
// Loads a DATA_BITS-wide payload and shifts it out LSB first, one bit per
// shift_en strobe. The CRC5 (x^5+x^2+1, preset 5'h1F) is accumulated on the
// fly and its inverted remainder follows, MSB first. done pulses for one clk
// after the last CRC bit.
//
// Optional feature macro: CRC5_GEN_BITSTUFF_EN (inserts a 0 after six
// consecutive transmitted 1s; stuffed bits do not touch counter or CRC).
//
// Ports:
//   clk        in   system clock
//   n_rst      in   asynchronous active-low reset
//   clear      in   synchronous abort to IDLE, CRC preset, no done pulse
//   load       in   capture data_in and start a packet (IDLE only)
//   data_in    in   payload, bit 0 transmitted first
//   shift_en   in   bit-period strobe, advances one bit
//   serial_out out  current line bit (1 when idle)
//   busy       out  high in DATA and CRC
//   done       out  one-cycle pulse after the last CRC bit
module crc_5bit_gen #(
  parameter int DATA_BITS = 11
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 shift_en,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  // Counter must hold DATA_BITS-1 and the CRC count up to 5.
  localparam int CW = ($clog2(DATA_BITS + 1) < 3) ? 3 : $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(4);
  localparam logic [CW-1:0] CRC_SENT  = CW'(5);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t               state, state_nx;
  logic [4:0]           crc, crc_nx;
  logic [DATA_BITS-1:0] sreg, sreg_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 stuff;        // a stuffed 0 is on the line now
  logic                 stuff_after;  // the CRC bit now on the line will trigger a stuff

`ifdef CRC5_GEN_BITSTUFF_EN
  logic [2:0] run, run_nx;
  logic       line_bit;

  assign stuff       = (run == 3'd6);
  assign stuff_after = ~crc[4] && (run == 3'd5);
  assign line_bit    = (state == DATA) ? sreg[0] : ~crc[4];

  always_comb begin
    run_nx = run;
    if (state == IDLE && load) begin
      run_nx = 3'd0;
    end else if ((state == DATA || state == CRC) && shift_en) begin
      run_nx = (stuff || !line_bit) ? 3'd0 : run + 3'd1;
    end
    if (clear) run_nx = 3'd0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) run <= 3'd0;
    else        run <= run_nx;
  end
`else
  assign stuff       = 1'b0;
  assign stuff_after = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    crc_nx     = crc;
    sreg_nx    = sreg;
    cnt_nx     = cnt;
    serial_out = 1'b1;
    case (state)
      IDLE: begin
        if (load) begin
          sreg_nx  = data_in;
          crc_nx   = 5'h1F;
          cnt_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        serial_out = stuff ? 1'b0 : sreg[0];
        if (shift_en && !stuff) begin
          crc_nx  = {crc[3:0], 1'b0} ^ ((crc[4] ^ sreg[0]) ? 5'b00101 : 5'b00000);
          sreg_nx = sreg >> 1;
          if (cnt == LAST_DATA) begin
            cnt_nx   = '0;
            state_nx = CRC;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      CRC: begin
        serial_out = stuff ? 1'b0 : ~crc[4];
        if (shift_en) begin
          if (stuff) begin
            // Trailing stuff after the final CRC bit closes the packet.
            if (cnt == CRC_SENT) state_nx = DONE;
          end else begin
            crc_nx = {crc[3:0], 1'b0};
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST_CRC && !stuff_after) state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clear) begin
      state_nx = IDLE;
      crc_nx   = 5'h1F;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      crc   <= 5'h1F;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      crc   <= crc_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  assign busy = (state == DATA) || (state == CRC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_crc_5bit_gen.sv
// tb/tb_crc_5bit_gen.sv - self-checking bench for crc_5bit_gen
module tb_crc_5bit_gen;

  localparam int DATA_BITS = 11;
`ifdef CRC5_GEN_BITSTUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 clear;
  logic                 load;
  logic [DATA_BITS-1:0] data_in;
  logic                 shift_en;
  logic                 serial_out;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit obs_q[$];
  logic [15:0] known = 16'b1010_1000_1111_0111;

  always #5 clk = ~clk;

  crc_5bit_gen #(.DATA_BITS(DATA_BITS)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .load       (load),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: USB token bit stream = payload LSB first, then the inverted
  // CRC5 remainder MSB first, with optional bit stuffing on the line.
  task automatic build_expected(input logic [DATA_BITS-1:0] d);
    bit raw[$];
    logic [4:0] c;
    int run;
    c = 5'h1F;
    raw.delete();
    for (int i = 0; i < DATA_BITS; i++) begin
      raw.push_back(d[i]);
      if (c[4] ^ d[i]) c = (c << 1) ^ 5'b00101;
      else             c = c << 1;
    end
    for (int i = 4; i >= 0; i--) raw.push_back(~c[i]);
    exp_q.delete();
    run = 0;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (STUFF && run == 6) begin
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
  endtask

  // Receive-side checker: destuff then run every bit through the CRC5.
  function automatic logic [4:0] residual(input bit q[$]);
    logic [4:0] c;
    int run;
    bit skip;
    c = 5'h1F;
    run = 0;
    skip = 1'b0;
    foreach (q[i]) begin
      if (skip) begin
        skip = 1'b0;
        run = 0;
      end else begin
        if (c[4] ^ q[i]) c = (c << 1) ^ 5'b00101;
        else             c = c << 1;
        run = q[i] ? run + 1 : 0;
        if (STUFF && run == 6) skip = 1'b1;
      end
    end
    return c;
  endfunction

  // Drives one packet. Starts and ends on a negedge.
  task automatic run_packet(input logic [DATA_BITS-1:0] d, input int max_gap,
                            input bit load_shift, input bit noise_load, input string tag);
    int gap;
    build_expected(d);
    obs_q.delete();
    @(negedge clk);
    data_in = d; load = 1'b1; shift_en = load_shift;
    @(negedge clk);
    load = noise_load; data_in = noise_load ? '0 : DATA_BITS'($urandom);
    foreach (exp_q[i]) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        shift_en = 1'b0;
        @(negedge clk);
      end
      obs_q.push_back(serial_out);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      shift_en = 1'b1;
      @(negedge clk);
    end
    shift_en = 1'b0; load = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_line_at_done"}, serial_out, 1'b1);
    foreach (exp_q[i]) check({tag, "_bit"}, obs_q[i], exp_q[i]);
    check({tag, "_residual"}, residual(obs_q), 5'b01100);
    @(negedge clk);
    check({tag, "_done_1clk"}, done, 1'b0);
  endtask

  task automatic check_known(input string tag);
    check({tag, "_len"}, obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      check({tag, "_known"}, obs_q[i], known[15-i]);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; load = 1'b0; shift_en = 1'b0; data_in = '0;
    #1;
    check("rst_line", serial_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;

    // Strobes in IDLE change nothing.
    shift_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_line", serial_out, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end
    shift_en = 1'b0;

    // Known vector with sparse strobes.
    run_packet(11'h715, 3, 1'b0, 1'b0, "known");
    check_known("known");

    // load with shift_en in the same cycle: load wins.
    run_packet(11'h715, 2, 1'b1, 1'b0, "ldshift");
    check_known("ldshift");

    // load during the packet is ignored.
    run_packet(11'h715, 2, 1'b0, 1'b1, "ignload");
    check_known("ignload");

    // Abort at the 5th data bit; clear beats simultaneous load.
    @(negedge clk);
    data_in = 11'h715; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) begin
      shift_en = 1'b1;
      @(negedge clk);
    end
    check("abort_5th_bit", serial_out, 1'b1);
    check("abort_busy_before", busy, 1'b1);
    clear = 1'b1; load = 1'b1; data_in = 11'h000;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; shift_en = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_line", serial_out, 1'b1);
    @(negedge clk);
    check("abort_done_later", done, 1'b0);
    check("abort_idle", busy, 1'b0);
    run_packet(11'h715, 1, 1'b0, 1'b0, "after_abort");
    check_known("after_abort");

    // Back-to-back strobes from load.
    run_packet(11'h715, 0, 1'b1, 1'b0, "b2b");
    check_known("b2b");

    // Asynchronous reset mid-packet.
    @(negedge clk);
    data_in = 11'h5A3; load = 1'b1;
    @(negedge clk);
    load = 1'b0; shift_en = 1'b1;
    repeat (6) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_line", serial_out, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    n_rst = 1'b1; shift_en = 1'b0;

`ifdef CRC5_GEN_BITSTUFF_EN
    run_packet(11'h7FF, 2, 1'b0, 1'b0, "stuff7ff");
    check("stuff7ff_zero", obs_q[6], 1'b0);
    check("stuff7ff_len_gt16", (obs_q.size() > 16), 1'b1);
`endif

    // Randomized payloads and strobe spacing.
    for (int p = 0; p < 12; p++) begin
      run_packet(DATA_BITS'($urandom), (p % 3), p[0], p[1], "rand");
    end
    run_packet(11'h7FF, 1, 1'b0, 1'b0, "ones");
    run_packet(11'h000, 1, 1'b0, 1'b0, "zeros");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_5bit_gen.md
Name: crc_5bit_gen

Overview:
- Transmit-side serializer for USB token packets: loads an 11-bit address/endpoint field and shifts it out LSB first, one bit per shift_en.
- Computes the CRC5 over the payload on the fly and appends the inverted remainder, MSB first.
- Sits between the TX packet controller and the bit encoder.
- A stream from this block, fed to the receive-side CRC5 checker, leaves residual 5'b01100.

Parameters:
DATA_BITS, 11, payload bits serialized before the CRC field (token: 7 addr + 4 endp)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns to IDLE, CRC preset
load  input  1  capture data_in and start a packet field (accepted only in IDLE)
data_in  input  DATA_BITS  payload, bit 0 transmitted first
shift_en  input  1  bit-period strobe from TX timer; advances one bit
serial_out  output  1  current bit to the encoder
busy  output  1  high in DATA and CRC states
done  output  1  one-cycle pulse after the last CRC bit is shifted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on n_rst.
- Reset values: state=IDLE, crc=5'h1F, data shift register=0, bit counter=0, serial_out=1, busy=0, done=0.
- CRC:
  - Polynomial x^5+x^2+1.
  - Per data bit b: fb=crc[4]^b; crc=crc<<1; if fb, crc^=5'b00101.
  - Bit width fixed at 5.
- States: IDLE, DATA, CRC, DONE.
- IDLE:
  - serial_out=1; shift_en ignored.
  - load=1 -> capture data_in, crc=5'h1F, counter=0, go to DATA next cycle.
  - load and shift_en in the same cycle: load wins, shift ignored.
- DATA:
  - serial_out = shift register bit 0 (combinational from state and registers, valid the cycle DATA is entered).
  - On shift_en: update crc with the current bit, shift the register right, counter++.
  - When the counter reaches DATA_BITS on that shift: counter=0, go to CRC.
- CRC:
  - serial_out = ~crc[4].
  - On shift_en: crc=crc<<1 (no feedback), counter++.
  - After 5 shifts: go to DONE.
- DONE: done=1 for exactly one clk, busy=0, serial_out=1; unconditionally return to IDLE.
- load while busy or in DONE is ignored; the captured payload is not disturbed.
- shift_en held high: one bit advances per clk; back-to-back strobes are legal.
- clear:
  - Highest priority below reset; any state -> IDLE next cycle, crc=5'h1F, counter=0.
  - No done pulse is produced.
  - clear together with load: clear wins.
- Reset asserted mid-packet: immediate return to reset values; partial packet abandoned.
- Latency: load to first valid bit = 1 clk. A packet takes DATA_BITS+5 shift_en strobes; done follows 1 clk after the last strobe.

Optional Feature:
Macro: CRC5_GEN_BITSTUFF_EN
- Defined:
  - Track consecutive 1s on serial_out across DATA and CRC.
  - After six consecutive transmitted 1s, the next shift_en drives a stuffed 0. The stuffed bit does not advance the counter or update crc.
  - The run count resets on any transmitted 0, including the stuffed bit, and on load, clear or reset.
  - A stuff pending after the last CRC bit is sent before DONE.
- Undefined: no stuffing; exactly DATA_BITS+5 strobes per packet; the stuffing logic is absent.

Test Plan:
1. Known vector: load data_in=11'h715 (addr 0x15, endp 0xE), strobe 16 times -> data bits 1,0,1,0,1,0,0,0,1,1,1 then CRC bits 1,0,1,1,1 (remainder 5'b01000 inverted); done pulses once; receive-side CRC5 checker fed the same 16 bits reports residual 5'b01100.
2. Reset and idle: after n_rst pulse -> serial_out=1, busy=0, done=0. shift_en strobes in IDLE -> no change. load with shift_en same cycle -> first data bit still bit 0.
3. Ignored load: load=1 with data_in=11'h000 during DATA of the 11'h715 packet -> output stream identical to scenario 1.
4. Abort: clear at 5th data bit -> IDLE next clk, no done pulse. New load of 11'h715 -> stream identical to scenario 1.
5. Back-to-back: shift_en held high continuously from load -> 16 consecutive bits, done 1 clk after the 16th, busy low the same cycle.
6. With CRC5_GEN_BITSTUFF_EN defined: load 11'h7FF -> a 0 is inserted after the 6th transmitted 1. The destuffed stream passes the checker (residual 5'b01100). Total strobes to done = 16 plus the number of stuffed bits.
